// File: rtl/pid_sched_pkg.sv
// Shared types, widths and saturation helpers for the time-multiplexed PID scheduler.
package pid_sched_pkg;

    localparam int ERR_W  = 32;
    localparam int ACC_W  = 48;
    localparam int GAIN_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_P = 2'd1,
        CALC_I = 2'd2,
        CALC_D = 2'd3
    } state_t;

    // Symmetric clamp of a 33-bit value to [-lim, +lim], narrowed to ERR_W.
    function automatic logic signed [ERR_W-1:0] sat_sym(
        input logic signed [ERR_W:0] x,
        input logic signed [ERR_W:0] lim
    );
        logic signed [ERR_W:0] r;
        r = x;
        if (x > lim)
            r = lim;
        else if (x < -lim)
            r = -lim;
        return r[ERR_W-1:0];
    endfunction

    // Unipolar clamp of the shifted accumulator to [0, hi], narrowed to ERR_W.
    function automatic logic signed [ERR_W-1:0] sat_out(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] hi
    );
        logic signed [ACC_W-1:0] r;
        r = x;
        if (x < 0)
            r = '0;
        else if (x > hi)
            r = hi;
        return r[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or after ptr, wrapping at NCH.
module rr_arbiter #(
    parameter int NCH   = 2,
    parameter int PTR_W = 1
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             any
);

    int idx;

    // Scan requests starting from ptr and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!any && req[idx]) begin
                grant = PTR_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pid_scheduler.sv
// NCH-channel PID controller sharing one multiplier; one channel is served per 4-cycle slot.
module pid_scheduler
    import pid_sched_pkg::*;
#(
    parameter int                        NCH       = 2,
    parameter logic signed [GAIN_W-1:0]  K_P       = 16'sd18,
    parameter logic signed [GAIN_W-1:0]  K_I       = 16'sd10,
    parameter logic signed [GAIN_W-1:0]  K_D       = 16'sd10,
    parameter int                        OUT_SHIFT = 8,
    parameter int                        I_LIM     = 1000,
    parameter int                        OUT_MAX   = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*ERR_W-1:0]   error,
    input  logic [NCH-1:0]         error_valid,
    input  logic                   clr,
    output logic [NCH*ERR_W-1:0]   ctrl_out,
    output logic [NCH-1:0]         out_valid,
    output logic                   busy
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         ptr, gsel, grant, grant_inc;
    logic                     any_req;
    logic [NCH-1:0]           pending;

    logic signed [ERR_W-1:0]  err_in [NCH];
    logic signed [ERR_W-1:0]  sample [NCH];
    logic signed [ERR_W-1:0]  integ  [NCH];
    logic signed [ERR_W-1:0]  prev   [NCH];
    logic signed [ERR_W-1:0]  ctrl_q [NCH];
    logic signed [ERR_W-1:0]  e;

    logic signed [ACC_W-1:0]  acc, acc_sum, gain_x, op_x, prod;
    logic signed [ERR_W:0]    integ_sum, diff, mul_op;
    logic signed [GAIN_W-1:0] mul_gain;
    logic signed [ERR_W-1:0]  inew, out_sat;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign err_in[c]                    = error[c*ERR_W +: ERR_W];
        assign ctrl_out[c*ERR_W +: ERR_W]   = ctrl_q[c];
    end

    rr_arbiter #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .any   (any_req)
    );

    assign grant_inc = (grant == PTR_W'(NCH - 1)) ? '0 : grant + 1'b1;
    assign busy      = (state != IDLE);

    // Fixed P -> I -> D sequence once a channel is granted; clr aborts to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CALC_P;
            CALC_P:  state_nxt = CALC_I;
            CALC_I:  state_nxt = CALC_D;
            CALC_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    // Per-phase operand select into the single shared multiplier, plus output saturation.
    always_comb begin
        integ_sum = {integ[gsel][ERR_W-1], integ[gsel]} + {e[ERR_W-1], e};
        inew      = sat_sym(integ_sum, (ERR_W+1)'(I_LIM));
        diff      = {e[ERR_W-1], e} - {prev[gsel][ERR_W-1], prev[gsel]};
        mul_gain  = '0;
        mul_op    = '0;
        case (state)
            CALC_P: begin mul_gain = K_P; mul_op = {e[ERR_W-1], e};       end
            CALC_I: begin mul_gain = K_I; mul_op = {inew[ERR_W-1], inew}; end
            CALC_D: begin mul_gain = K_D; mul_op = diff;                  end
            default: ;
        endcase
        gain_x  = {{(ACC_W-GAIN_W){mul_gain[GAIN_W-1]}}, mul_gain};
        op_x    = {{(ACC_W-ERR_W-1){mul_op[ERR_W]}}, mul_op};
        prod    = gain_x * op_x;
        acc_sum = acc + prod;
        out_sat = sat_out(acc_sum >>> OUT_SHIFT, ACC_W'(OUT_MAX));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Sample capture, grant bookkeeping, accumulation and per-channel history/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            gsel      <= '0;
            pending   <= '0;
            e         <= '0;
            acc       <= '0;
            out_valid <= '0;
            // NOTE: the per-channel arrays are small register files that must come up zeroed, so they sit in the reset branch.
            for (int c = 0; c < NCH; c++) begin
                sample[c] <= '0;
                integ[c]  <= '0;
                prev[c]   <= '0;
                ctrl_q[c] <= '0;
            end
        end else begin
            out_valid <= '0;
            if (clr) begin
                pending <= '0;
                for (int c = 0; c < NCH; c++) begin
                    integ[c] <= '0;
                    prev[c]  <= '0;
                end
            end else begin
                if (state == IDLE && any_req) begin
                    gsel           <= grant;
                    e              <= sample[grant];
                    pending[grant] <= 1'b0;
                    ptr            <= grant_inc;
                end
                // A strobe on the grant edge re-arms pending, overriding the clear above.
                for (int c = 0; c < NCH; c++) begin
                    if (error_valid[c]) begin
                        sample[c]  <= err_in[c];
                        pending[c] <= 1'b1;
                    end
                end
                case (state)
                    CALC_P: acc <= prod;
                    CALC_I: begin
                        acc         <= acc_sum;
                        integ[gsel] <= inew;
                    end
                    CALC_D: begin
                        acc             <= acc_sum;
                        prev[gsel]      <= e;
                        ctrl_q[gsel]    <= out_sat;
                        out_valid[gsel] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_scheduler.sv
// Scoreboard bench for pid_scheduler: a transaction-level model predicts each result and its edge.
module tb_pid_scheduler;

    localparam int     NCH  = 2;
    localparam longint KP   = 18;
    localparam longint KI   = 10;
    localparam longint KD   = 10;
    localparam int     SH   = 8;
    localparam longint ILIM = 1000;
    localparam longint OMAX = 1000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*32-1:0]    error;
    logic [NCH-1:0]       error_valid;
    logic                 clr;
    logic [NCH*32-1:0]    ctrl_out;
    logic [NCH-1:0]       out_valid;
    logic                 busy;

    pid_scheduler #(
        .NCH       (NCH),
        .K_P       (16'sd18),
        .K_I       (16'sd10),
        .K_D       (16'sd10),
        .OUT_SHIFT (8),
        .I_LIM     (1000),
        .OUT_MAX   (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .error       (error),
        .error_valid (error_valid),
        .clr         (clr),
        .ctrl_out    (ctrl_out),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   sb [NCH][$];
    exp_t   mon_x;

    longint m_sample [NCH];
    longint m_integ  [NCH];
    longint m_prev   [NCH];
    longint m_last   [NCH];
    bit     m_pend   [NCH];
    int     m_ptr, m_cnt, m_g;
    longint m_e;
    int     edge_n = 0;
    int     ov_edge [NCH];
    int     s_edge;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic longint out_of(input int c);
        return longint'($signed(ctrl_out[c*32 +: 32]));
    endfunction

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sample[c] = 0;
            m_integ[c]  = 0;
            m_prev[c]   = 0;
            m_last[c]   = 0;
            m_pend[c]   = 1'b0;
            ov_edge[c]  = -1;
            sb[c].delete();
        end
        m_ptr = 0;
        m_cnt = 0;
        m_g   = 0;
        m_e   = 0;
    endtask

    // Called right at each rising edge with the inputs the DUT is sampling.
    task automatic model_edge();
        longint inew, acc, y;
        bit     found;
        edge_n++;
        if (!rst_n) return;
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c]  = 1'b0;
                m_integ[c] = 0;
                m_prev[c]  = 0;
            end
            m_cnt = 0;
            return;
        end
        if (m_cnt == 0) begin
            found = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                int idx;
                idx = (m_ptr + i) % NCH;
                if (!found && m_pend[idx]) begin
                    found       = 1'b1;
                    m_g         = idx;
                    m_e         = m_sample[idx];
                    m_pend[idx] = 1'b0;
                    m_ptr       = (idx + 1) % NCH;
                    m_cnt       = 3;
                end
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                inew = clampl(m_integ[m_g] + m_e, -ILIM, ILIM);
                acc  = KP * m_e + KI * inew + KD * (m_e - m_prev[m_g]);
                y    = clampl(acc >>> SH, 0, OMAX);
                m_integ[m_g] = inew;
                m_prev[m_g]  = m_e;
                sb[m_g].push_back('{val: y, cyc: edge_n});
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (error_valid[c]) begin
                m_sample[c] = longint'($signed(error[c*32 +: 32]));
                m_pend[c]   = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [NCH-1:0] mask, input longint v0, input longint v1);
        error[31:0]  = 32'(v0);
        error[63:32] = 32'(v1);
        error_valid  = mask;
        tick();
        s_edge       = edge_n;
        error_valid  = '0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        error_valid = '0;
        clr         = 1'b0;
        model_reset();
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        for (int c = 0; c < NCH; c++) check("rst_ctrl_out", out_of(c), 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every out_valid and checks hold/busy every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (sb[c].size() > 0 && sb[c][0].cyc < edge_n) begin
                    check("out_valid_missing", 0, 1);
                    void'(sb[c].pop_front());
                end
                if (out_valid[c]) begin
                    if (sb[c].size() == 0) begin
                        check("out_valid_unexpected", 1, 0);
                    end else begin
                        mon_x = sb[c].pop_front();
                        check("ctrl_out_value", out_of(c), mon_x.val);
                        check("out_valid_edge", longint'(edge_n), longint'(mon_x.cyc));
                        m_last[c]  = mon_x.val;
                        ov_edge[c] = edge_n;
                    end
                end
                check("ctrl_out_hold", out_of(c), m_last[c]);
            end
            check("busy", longint'(busy), longint'(m_cnt != 0));
        end
    end

    initial begin
        error       = '0;
        error_valid = '0;
        clr         = 1'b0;
        do_reset();

        // Basic response and second-sample integration.
        strobe(2'b01, 256, 0);
        idle(6);
        check("e256_out", out_of(0), 38);
        check("e256_latency", longint'(ov_edge[0] - s_edge), 4);
        strobe(2'b01, 256, 0);
        idle(6);
        check("e256_second_out", out_of(0), 38);

        // Saturation at both ends.
        do_reset();
        strobe(2'b01, 100000, 0);
        idle(6);
        check("sat_high", out_of(0), 1000);
        do_reset();
        strobe(2'b01, -256, 0);
        idle(6);
        check("sat_low", out_of(0), 0);
        check("sat_low_pulse", longint'(ov_edge[0] - s_edge), 4);

        // Integrator clamp.
        do_reset();
        strobe(2'b01, 600, 0);
        idle(6);
        check("i600_first", out_of(0), 89);
        strobe(2'b01, 600, 0);
        idle(6);
        check("i600_clamped", out_of(0), 81);

        // Simultaneous strobes served in round-robin order, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            strobe(2'b11, 256, 256);
            idle(10);
            check("rr_ch0_latency", longint'(ov_edge[0] - s_edge), 4);
            check("rr_ch1_latency", longint'(ov_edge[1] - s_edge), 8);
        end

        // clr while in CALC_I: abort, keep ctrl_out, wipe history.
        do_reset();
        strobe(2'b01, 600, 0);
        idle(6);
        strobe(2'b01, 256, 0);
        tick();
        tick();
        check("busy_before_clr", longint'(busy), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", longint'(busy), 0);
        idle(5);
        check("clr_keeps_out", out_of(0), 89);
        strobe(2'b01, 256, 0);
        idle(6);
        check("after_clr_out", out_of(0), 38);

        // Reset in CALC_D: no pulse, everything zero.
        strobe(2'b10, 0, 500);
        tick();
        tick();
        tick();
        check("busy_in_calc_d", longint'(busy), 1);
        #2;
        do_reset();
        idle(6);
        check("post_rst_ch1", out_of(1), 0);

        // Randomised traffic with overwrites, contention and occasional clr.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                longint v;
                if ($urandom_range(0, 9) == 0)
                    v = longint'($signed(32'($urandom)));
                else
                    v = longint'($urandom_range(0, 6000)) - 3000;
                error[c*32 +: 32] = 32'(v);
                error_valid[c]    = ($urandom_range(0, 3) == 0);
            end
            clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        error_valid = '0;
        clr         = 1'b0;
        idle(12);
        for (int c = 0; c < NCH; c++) check("drain_empty", longint'(sb[c].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
